// File: rtl/dm_ahb_master.sv
// ---------------------------------------------------------------------------
// dm_ahb_master
//
// Data-memory port that turns single processor load/store requests into
// single AHB-Lite transfers (NONSEQ only, never SEQ/BUSY) and returns a
// one-cycle done/err pulse plus an extended load result.
//
// Ports
//   HCLK                 sole clock, rising edge
//   reset                synchronous, active-high reset
//   proc2dm_command[1:0] 0 NONE, 1 LOAD, 2 STORE, 3 reserved (= NONE)
//   proc2dm_addr[31:0]   byte address
//   proc2dm_size[1:0]    0 byte, 1 half, 2 word, 3 (= word)
//   proc2dm_unsigned     load zero-extends when 1, sign-extends when 0
//   proc2dm_data[31:0]   store data, right-justified
//   dm2proc_ready        high in IDLE; request accepted when command valid
//   dm2proc_done         one-cycle completion pulse
//   dm2proc_err          one-cycle error pulse, always together with done
//   dm2proc_data[31:0]   extended load result, held between loads
//   HADDR/HSIZE/HWRITE/HTRANS/HWDATA  AHB-Lite master outputs
//   HRDATA/HREADY/HRESP                AHB-Lite slave responses
//
// Configuration macro: DM_AHB_ALIGN_CHECK_EN
//   defined   : misaligned half/word requests complete immediately with
//               err=1 and no bus transfer.
//   undefined : misaligned addresses are aligned down to the access size and
//               the transfer proceeds normally.
// ---------------------------------------------------------------------------
module dm_ahb_master (
  input  logic        HCLK,
  input  logic        reset,
  input  logic [1:0]  proc2dm_command,
  input  logic [31:0] proc2dm_addr,
  input  logic [1:0]  proc2dm_size,
  input  logic        proc2dm_unsigned,
  input  logic [31:0] proc2dm_data,
  output logic        dm2proc_ready,
  output logic        dm2proc_done,
  output logic        dm2proc_err,
  output logic [31:0] dm2proc_data,
  output logic [31:0] HADDR,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req_valid_s;
  logic [1:0]  size_norm_s;
  logic        misaligned_s;

  // Replicate right-justified store data across all byte lanes of its size.
  function automatic logic [31:0] replicate_wdata(input logic [31:0] data,
                                                  input logic [1:0]  size);
    logic [31:0] res;
    case (size)
      2'd0:    res = {4{data[7:0]}};
      2'd1:    res = {2{data[15:0]}};
      default: res = data;
    endcase
    return res;
  endfunction

  // Clear the low address bits that lie inside the access size.
  function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                             input logic [1:0]  size);
    logic [31:0] res;
    case (size)
      2'd0:    res = addr;
      2'd1:    res = {addr[31:1], 1'b0};
      default: res = {addr[31:2], 2'b00};
    endcase
    return res;
  endfunction

  // Pick the little-endian lane addressed by the request and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  addr_lo,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (addr_lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'd0:    res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = rdata;
    endcase
    return res;
  endfunction

  assign req_valid_s  = (proc2dm_command == 2'd1) || (proc2dm_command == 2'd2);
  assign size_norm_s  = (proc2dm_size == 2'd3) ? 2'd2 : proc2dm_size;
  assign misaligned_s = ((size_norm_s == 2'd1) && proc2dm_addr[0]) ||
                        ((size_norm_s == 2'd2) && (proc2dm_addr[1:0] != 2'd0));

  // Next-state, request capture and completion pulses.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    write_d = write_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_s) begin
`ifdef DM_AHB_ALIGN_CHECK_EN
          if (misaligned_s) begin
            // Rejected without touching the bus; err pulses next cycle.
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_d  = proc2dm_addr;
            size_d  = size_norm_s;
            uns_d   = proc2dm_unsigned;
            write_d = (proc2dm_command == 2'd2);
            wdata_d = replicate_wdata(proc2dm_data, size_norm_s);
            state_d = ST_ADDR;
          end
`else
          addr_d  = align_addr(proc2dm_addr, size_norm_s);
          size_d  = size_norm_s;
          uns_d   = proc2dm_unsigned;
          write_d = (proc2dm_command == 2'd2);
          wdata_d = replicate_wdata(proc2dm_data, size_norm_s);
          state_d = ST_ADDR;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ADDR: begin
        if (HREADY) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end

      ST_DATA: begin
        if (HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (HRESP) begin
            // Error reported on the final cycle only: treat as failed.
            err_d = 1'b1;
          end else if (!write_q) begin
            rdata_d = load_extend(HRDATA, size_q, addr_q[1:0], uns_q);
          end else begin
            rdata_d = rdata_q;
          end
        end else if (HRESP) begin
          // First cycle of the two-cycle ERROR response.
          state_d = ST_ERR;
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_ERR: begin
        if (HREADY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_ERR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // All outputs are flops or a decode of the state flop.
  assign HTRANS        = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
  assign HADDR         = addr_q;
  assign HSIZE         = {1'b0, size_q};
  assign HWRITE        = write_q;
  assign HWDATA        = wdata_q;
  assign dm2proc_ready = (state_q == ST_IDLE);
  assign dm2proc_done  = done_q;
  assign dm2proc_err   = err_q;
  assign dm2proc_data  = rdata_q;

endmodule

// File: tb/tb_dm_ahb_master.sv
module tb_dm_ahb_master;

  logic        HCLK;
  logic        reset;
  logic [1:0]  proc2dm_command;
  logic [31:0] proc2dm_addr;
  logic [1:0]  proc2dm_size;
  logic        proc2dm_unsigned;
  logic [31:0] proc2dm_data;
  logic        dm2proc_ready;
  logic        dm2proc_done;
  logic        dm2proc_err;
  logic [31:0] dm2proc_data;
  logic [31:0] HADDR;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_checks = 0;
  int n_errors = 0;

  dm_ahb_master dut (
    .HCLK             (HCLK),
    .reset            (reset),
    .proc2dm_command  (proc2dm_command),
    .proc2dm_addr     (proc2dm_addr),
    .proc2dm_size     (proc2dm_size),
    .proc2dm_unsigned (proc2dm_unsigned),
    .proc2dm_data     (proc2dm_data),
    .dm2proc_ready    (dm2proc_ready),
    .dm2proc_done     (dm2proc_done),
    .dm2proc_err      (dm2proc_err),
    .dm2proc_data     (dm2proc_data),
    .HADDR            (HADDR),
    .HSIZE            (HSIZE),
    .HWRITE           (HWRITE),
    .HTRANS           (HTRANS),
    .HWDATA           (HWDATA),
    .HRDATA           (HRDATA),
    .HREADY           (HREADY),
    .HRESP            (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_hwdata;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] cmd, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    proc2dm_command  = cmd;
    proc2dm_addr     = addr;
    proc2dm_size     = size;
    proc2dm_unsigned = uns;
    proc2dm_data     = wdata;
  endtask

  task automatic run_vec(input int i);
    string tag;
    tag = $sformatf("vec%0d", i);
    HREADY = 1'b1;
    HRESP  = 1'b0;
    drive_req(vecs[i].cmd, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata);
    check({tag, ".ready"}, {31'd0, dm2proc_ready}, 32'd1);
    tick();  // E0: accepted
    proc2dm_command = 2'd0;
    check({tag, ".htrans_addr"}, {30'd0, HTRANS}, 32'd2);
    check({tag, ".haddr"}, HADDR, vecs[i].exp_haddr);
    check({tag, ".hsize"}, {29'd0, HSIZE}, {29'd0, vecs[i].exp_hsize});
    check({tag, ".hwrite"}, {31'd0, HWRITE}, {31'd0, (vecs[i].cmd == 2'd2)});
    tick();  // DATA phase
    check({tag, ".htrans_data"}, {30'd0, HTRANS}, 32'd0);
    check({tag, ".done_early"}, {31'd0, dm2proc_done}, 32'd0);
    if (vecs[i].cmd == 2'd2) check({tag, ".hwdata"}, HWDATA, vecs[i].exp_hwdata);
    HRDATA = vecs[i].rdata;
    tick();  // completion visible, back in IDLE
    check({tag, ".done"}, {31'd0, dm2proc_done}, 32'd1);
    check({tag, ".err"}, {31'd0, dm2proc_err}, 32'd0);
    check({tag, ".data"}, dm2proc_data, vecs[i].exp_data);
    check({tag, ".ready_after"}, {31'd0, dm2proc_ready}, 32'd1);
    tick();
    check({tag, ".done_once"}, {31'd0, dm2proc_done}, 32'd0);
  endtask

  initial begin
    // cmd, addr, size, uns, wdata, rdata, exp_data, exp_haddr, exp_hsize, exp_hwdata
    vecs[0]  = '{2'd1, 32'h0000_0100, 2'd2, 1'b0, 32'h0, 32'h8899_AABB, 32'h8899_AABB, 32'h0000_0100, 3'd2, 32'h0};
    vecs[1]  = '{2'd1, 32'h0000_0101, 2'd0, 1'b0, 32'h0, 32'h8899_AABB, 32'hFFFF_FFAA, 32'h0000_0101, 3'd0, 32'h0};
    vecs[2]  = '{2'd1, 32'h0000_0101, 2'd0, 1'b1, 32'h0, 32'h8899_AABB, 32'h0000_00AA, 32'h0000_0101, 3'd0, 32'h0};
    vecs[3]  = '{2'd1, 32'h0000_0102, 2'd1, 1'b0, 32'h0, 32'h8899_AABB, 32'hFFFF_8899, 32'h0000_0102, 3'd1, 32'h0};
    vecs[4]  = '{2'd1, 32'h0000_0100, 2'd1, 1'b1, 32'h0, 32'h8899_AABB, 32'h0000_AABB, 32'h0000_0100, 3'd1, 32'h0};
    vecs[5]  = '{2'd1, 32'h0000_0103, 2'd0, 1'b0, 32'h0, 32'h7F00_0000, 32'h0000_007F, 32'h0000_0103, 3'd0, 32'h0};
    vecs[6]  = '{2'd2, 32'h0000_0200, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0000_007F, 32'h0000_0200, 3'd2, 32'hDEAD_BEEF};
    vecs[7]  = '{2'd2, 32'h0000_0203, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 32'h0000_007F, 32'h0000_0203, 3'd0, 32'hA5A5_A5A5};
    vecs[8]  = '{2'd1, 32'h0000_0100, 2'd1, 1'b0, 32'h0, 32'h0000_8001, 32'hFFFF_8001, 32'h0000_0100, 3'd1, 32'h0};
    vecs[9]  = '{2'd1, 32'h0000_0300, 2'd3, 1'b0, 32'h0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0300, 3'd2, 32'h0};
    vecs[10] = '{2'd1, 32'h0000_0200, 2'd0, 1'b0, 32'h0, 32'h0000_0080, 32'hFFFF_FF80, 32'h0000_0200, 3'd0, 32'h0};
    vecs[11] = '{2'd1, 32'h0000_0206, 2'd0, 1'b1, 32'h0, 32'h00C3_0000, 32'h0000_00C3, 32'h0000_0206, 3'd0, 32'h0};

    reset  = 1'b1;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    drive_req(2'd0, 32'h0, 2'd0, 1'b0, 32'h0);
    tick();
    tick();
    // Reset state
    check("rst.htrans", {30'd0, HTRANS}, 32'd0);
    check("rst.haddr", HADDR, 32'd0);
    check("rst.hsize", {29'd0, HSIZE}, 32'd0);
    check("rst.hwrite", {31'd0, HWRITE}, 32'd0);
    check("rst.hwdata", HWDATA, 32'd0);
    check("rst.done", {31'd0, dm2proc_done}, 32'd0);
    check("rst.err", {31'd0, dm2proc_err}, 32'd0);
    check("rst.data", dm2proc_data, 32'd0);
    reset = 1'b0;
    tick();
    check("rst.ready", {31'd0, dm2proc_ready}, 32'd1);

    // Table-driven zero-wait transfers
    for (int i = 0; i < 12; i++) run_vec(i);

    // Reserved command 3 behaves as NONE
    drive_req(2'd3, 32'h0000_0400, 2'd2, 1'b0, 32'h0);
    tick();
    check("rsvd.htrans", {30'd0, HTRANS}, 32'd0);
    check("rsvd.ready", {31'd0, dm2proc_ready}, 32'd1);
    tick();
    check("rsvd.done", {31'd0, dm2proc_done}, 32'd0);
    proc2dm_command = 2'd0;

    // Half store with two wait states: done at E0+5
    drive_req(2'd2, 32'h0000_0102, 2'd1, 1'b0, 32'h0000_1234);
    HREADY = 1'b1;
    tick();  // E0
    proc2dm_command = 2'd0;
    check("ws.htrans_addr", {30'd0, HTRANS}, 32'd2);
    check("ws.hsize", {29'd0, HSIZE}, 32'd1);
    check("ws.hwrite", {31'd0, HWRITE}, 32'd1);
    tick();  // E0+1 -> DATA
    HREADY = 1'b0;
    check("ws.hwdata0", HWDATA, 32'h1234_1234);
    tick();  // E0+2 wait
    check("ws.hwdata1", HWDATA, 32'h1234_1234);
    check("ws.htrans_wait", {30'd0, HTRANS}, 32'd0);
    check("ws.done_w1", {31'd0, dm2proc_done}, 32'd0);
    tick();  // E0+3 wait
    check("ws.hwdata2", HWDATA, 32'h1234_1234);
    check("ws.done_w2", {31'd0, dm2proc_done}, 32'd0);
    HREADY = 1'b1;
    tick();  // E0+4 complete
    check("ws.done", {31'd0, dm2proc_done}, 32'd1);
    check("ws.err", {31'd0, dm2proc_err}, 32'd0);
    check("ws.data_kept", dm2proc_data, 32'h0000_00C3);

    // Back-to-back: new request accepted in the done cycle
    drive_req(2'd1, 32'h0000_0504, 2'd2, 1'b0, 32'h0);
    check("b2b.ready_with_done", {31'd0, dm2proc_ready}, 32'd1);
    tick();
    proc2dm_command = 2'd0;
    check("b2b.htrans", {30'd0, HTRANS}, 32'd2);
    check("b2b.haddr", HADDR, 32'h0000_0504);
    check("b2b.done_cleared", {31'd0, dm2proc_done}, 32'd0);
    tick();
    HRDATA = 32'h5566_7788;
    tick();
    check("b2b.done", {31'd0, dm2proc_done}, 32'd1);
    check("b2b.data", dm2proc_data, 32'h5566_7788);
    tick();

    // Two-cycle ERROR response
    drive_req(2'd1, 32'h0000_0600, 2'd2, 1'b0, 32'h0);
    HRDATA = 32'hDEAD_DEAD;
    tick();
    proc2dm_command = 2'd0;
    tick();  // DATA
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick();  // ERR
    check("err.htrans", {30'd0, HTRANS}, 32'd0);
    check("err.done_early", {31'd0, dm2proc_done}, 32'd0);
    HREADY = 1'b1;
    tick();
    HRESP = 1'b0;
    check("err.done", {31'd0, dm2proc_done}, 32'd1);
    check("err.err", {31'd0, dm2proc_err}, 32'd1);
    check("err.data_kept", dm2proc_data, 32'h5566_7788);
    tick();
    check("err.done_once", {31'd0, dm2proc_done}, 32'd0);
    check("err.err_once", {31'd0, dm2proc_err}, 32'd0);

    // Misaligned word load at 0x102
    drive_req(2'd1, 32'h0000_0102, 2'd2, 1'b0, 32'h0);
    HRDATA = 32'hCAFE_F00D;
    tick();  // E0
    proc2dm_command = 2'd0;
`ifdef DM_AHB_ALIGN_CHECK_EN
    check("mis.htrans", {30'd0, HTRANS}, 32'd0);
    check("mis.done", {31'd0, dm2proc_done}, 32'd1);
    check("mis.err", {31'd0, dm2proc_err}, 32'd1);
    check("mis.data_kept", dm2proc_data, 32'h5566_7788);
    tick();
    check("mis.done_once", {31'd0, dm2proc_done}, 32'd0);
`else
    check("mis.htrans", {30'd0, HTRANS}, 32'd2);
    check("mis.haddr", HADDR, 32'h0000_0100);
    tick();
    tick();
    check("mis.done", {31'd0, dm2proc_done}, 32'd1);
    check("mis.err", {31'd0, dm2proc_err}, 32'd0);
    check("mis.data", dm2proc_data, 32'hCAFE_F00D);
    tick();
`endif

    // Reset during a stalled DATA phase abandons the transfer
    drive_req(2'd1, 32'h0000_0700, 2'd2, 1'b0, 32'h0);
    tick();
    proc2dm_command = 2'd0;
    tick();  // DATA
    HREADY = 1'b0;
    tick();  // still DATA
    reset = 1'b1;
    tick();
    check("rstx.htrans", {30'd0, HTRANS}, 32'd0);
    check("rstx.done", {31'd0, dm2proc_done}, 32'd0);
    check("rstx.data", dm2proc_data, 32'd0);
    reset  = 1'b0;
    HREADY = 1'b1;
    tick();
    check("rstx.ready", {31'd0, dm2proc_ready}, 32'd1);
    check("rstx.no_done", {31'd0, dm2proc_done}, 32'd0);
    tick();
    check("rstx.no_done2", {31'd0, dm2proc_done}, 32'd0);
    check("rstx.htrans_idle", {30'd0, HTRANS}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_ahb_master.md
DM_AHB_MASTER -- requirements
Module: dm_ahb_master

Interface
- REQ-001 SHALL have these ports:
  - HCLK  in  1  sole clock; all state updates on the rising edge.
  - reset  in  1  synchronous, active-high reset.
  - proc2dm_command  in  2  request type: 0 NONE, 1 LOAD, 2 STORE, 3 reserved and treated as NONE.
  - proc2dm_addr  in  32  byte address.
  - proc2dm_size  in  2  access size: 0 byte, 1 half, 2 word, 3 treated as word.
  - proc2dm_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
  - proc2dm_data  in  32  store data, right-justified.
  - dm2proc_ready  out  1  request accepted this cycle when command is not NONE.
  - dm2proc_done  out  1  one-cycle completion pulse.
  - dm2proc_err  out  1  one-cycle error pulse; asserted together with done.
  - dm2proc_data  out  32  extended load result.
  - HADDR  out  32  AHB-Lite address.
  - HSIZE  out  3  AHB-Lite transfer size.
  - HWRITE  out  1  AHB-Lite write enable.
  - HTRANS  out  2  AHB-Lite transfer type.
  - HWDATA  out  32  AHB-Lite write data.
  - HRDATA  in  32  AHB-Lite read data.
  - HREADY  in  1  AHB-Lite ready.
  - HRESP  in  1  AHB-Lite response; 1 means ERROR.

Function
- REQ-002 SHALL use FSM states IDLE, ADDR, DATA and ERR.
- REQ-003 SHALL drive dm2proc_ready=1 only in IDLE; a request is accepted on the edge where the state is IDLE and the command is LOAD or STORE.
- REQ-004 SHALL register addr, size, unsigned, write and data on acceptance, then move to ADDR.
- REQ-005 In ADDR, SHALL drive HTRANS=NONSEQ (2'b10) and drive HADDR, HSIZE and HWRITE from the registered request; SHALL move to DATA on the first edge with HREADY=1.
- REQ-006 In every state other than ADDR, SHALL drive HTRANS=IDLE (2'b00); only single transfers are issued, never SEQ or BUSY.
- REQ-007 In DATA, SHALL hold HWDATA stable, with the store byte replicated across lanes: byte to all 4 lanes, half to both halves.
- REQ-008 In DATA, when HREADY=1 and HRESP=0, SHALL return to IDLE and, on the next cycle, pulse done=1 and err=0 for exactly one cycle.
- REQ-009 On a completed LOAD, SHALL capture dm2proc_data at that same edge.
  - Lane is selected by addr[1:0] (byte) or addr[1] (half), little-endian.
  - The value is extended per the unsigned flag.
- REQ-010 In DATA, when HREADY=0 and HRESP=1, SHALL move to ERR.
- REQ-011 In ERR, SHALL move to IDLE on HREADY=1 and pulse done=1 and err=1 on the next cycle; dm2proc_data SHALL be unchanged.
- REQ-012 SHALL hold dm2proc_data between loads; stores SHALL not alter it.
- REQ-013 Zero-wait latency: acceptance edge E0, ADDR cycle, DATA cycle, done visible in cycle E0+3 while back in IDLE.
- REQ-014 A new request MAY be accepted in the same cycle as the done pulse, giving back-to-back operation.
- REQ-015 Each wait state (HREADY=0) SHALL add exactly one cycle to the latency.

Reset
- REQ-016 SHALL, while reset=1 at an edge, force the state to IDLE and set these outputs:
  - HTRANS=IDLE, HADDR=0, HSIZE=0, HWRITE=0, HWDATA=0.
  - done=0, err=0, dm2proc_data=0.
- REQ-017 Reset asserted mid-transfer SHALL abandon the transfer: HTRANS=IDLE from the next cycle, and no done is emitted.

Configuration
- REQ-018 Macro DM_AHB_ALIGN_CHECK_EN controls misaligned requests (half with addr[0]=1, or word with addr[1:0]!=0):
  - Defined: such a request SHALL be accepted with no bus transfer; HTRANS stays IDLE, and done=1, err=1 pulse on the cycle after acceptance.
  - Undefined: HADDR SHALL be aligned down to the access size, and the transfer SHALL proceed normally.

Verification
- REQ-019 Word LOAD at 0x100 (memory 0x8899AABB), zero-wait -> HTRANS=NONSEQ for one cycle, done at E0+3, data=0x8899AABB, err=0.
- REQ-020 Byte LOAD at 0x101, signed -> data=0xFFFFFFAA; the same access with unsigned=1 -> data=0x000000AA.
- REQ-021 Half STORE 0x1234 to 0x102 with 2 wait states -> HWDATA=0x12341234 held through DATA, HSIZE=1, done at E0+5.
- REQ-022 Slave returns HRESP=1 with HREADY=0, then HRESP=1 with HREADY=1 -> done=1, err=1 once, dm2proc_data unchanged.
- REQ-023 Word LOAD at 0x102 -> with the macro defined, no NONSEQ is issued and err pulses at E0+1; with it undefined, HADDR=0x100.
- REQ-024 Reset asserted during DATA with HREADY=0 -> HTRANS=IDLE the next cycle, no done, dm2proc_ready=1 after reset is released.
